// File: rtl/raster_pkg.sv
// -----------------------------------------------------------------------------
// raster_pkg
//
// Shared types and widths for the raster position counter.
//
// Contents:
//   MAX_WIDTH_DEF / MAX_HEIGHT_DEF : default frame limits used to size the types
//   X_W / Y_W                      : column / row coordinate widths
//   W_W / H_W                      : frame size field widths (can hold MAX itself)
//   frame_size_t                   : {width, height} pair for active/pending size
//   raster_state_e                 : IDLE (at origin) / ACTIVE (mid-frame)
//   size_in_range()                : 1 <= value <= max check for config requests
// -----------------------------------------------------------------------------
package raster_pkg;

  localparam int unsigned MAX_WIDTH_DEF  = 1920;
  localparam int unsigned MAX_HEIGHT_DEF = 1080;

  localparam int unsigned X_W = $clog2(MAX_WIDTH_DEF);
  localparam int unsigned Y_W = $clog2(MAX_HEIGHT_DEF);
  localparam int unsigned W_W = $clog2(MAX_WIDTH_DEF + 1);
  localparam int unsigned H_W = $clog2(MAX_HEIGHT_DEF + 1);

  typedef struct packed {
    logic [W_W-1:0] width;
    logic [H_W-1:0] height;
  } frame_size_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } raster_state_e;

  // A zero-length axis would never reach its terminal count, so 0 is illegal.
  function automatic logic size_in_range(input int unsigned value, input int unsigned max);
    return (value >= 1) && (value <= max);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
//
// Single-axis position counter with a run-time limit.
//
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset, count returns to 0
//   en_i     : advance by one this cycle
//   clr_i    : treat the current count as 0 this cycle; with en_i the counter
//              steps from 0, so it lands on 1 (or wraps to 0 when limit_i == 1)
//   limit_i  : axis length, 1..MAX_COUNT
//   cnt_o    : current count
//   tc_o     : current count is the last position (limit_i - 1)
//   wrap_o   : the position consumed this cycle (after clr_i) is the last one,
//              i.e. an en_i in this cycle wraps the counter to 0
// -----------------------------------------------------------------------------
module wrap_counter #(
  parameter int unsigned MAX_COUNT = 1920,
  localparam int unsigned CntW     = $clog2(MAX_COUNT),
  localparam int unsigned LimW     = $clog2(MAX_COUNT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [LimW-1:0] limit_i,
  output logic [CntW-1:0] cnt_o,
  output logic            tc_o,
  output logic            wrap_o
);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic [CntW-1:0] base;
  logic [LimW-1:0] last;

  always_comb begin
    last   = limit_i - LimW'(1);
    base   = clr_i ? '0 : cnt_q;
    tc_o   = (LimW'(cnt_q) == last);
    wrap_o = (LimW'(base) == last);
    // clr_i alone still zeroes the count: a resync mid-line clears the row
    // even when the column does not wrap.
    cnt_d  = base;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : base + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
//
// Two-dimensional pixel position counter with a double-buffered frame size.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   en                      : pixel accepted this cycle, advances the position
//   sof_in                  : external start-of-frame, only sampled with en
//   cfg_load                : one-cycle pulse capturing cfg_width / cfg_height
//   cfg_width, cfg_height   : requested frame size
//   x, y                    : position of the pixel consumed by the next en
//   sol, eol, sof, eof      : line / frame markers for that pixel (combinational)
//   in_frame                : position is not (0,0)
//   cfg_pending             : captured size waiting for the next frame boundary
//   frame_count             : completed frames, wrapping
//   sync_err                : pulse, sof_in arrived mid-frame (frame aborted)
//   cfg_err                 : pulse, out-of-range cfg_load rejected
//
// A new size only ever takes effect when the next position is (0,0), so a frame
// is always scanned with a single consistent size.
// -----------------------------------------------------------------------------
module raster_counter
  import raster_pkg::*;
#(
  parameter int unsigned MAX_WIDTH   = MAX_WIDTH_DEF,
  parameter int unsigned MAX_HEIGHT  = MAX_HEIGHT_DEF,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sof_in,
  input  logic                   cfg_load,
  input  logic [W_W-1:0]         cfg_width,
  input  logic [H_W-1:0]         cfg_height,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic                   sol,
  output logic                   eol,
  output logic                   sof,
  output logic                   eof,
  output logic                   in_frame,
  output logic                   cfg_pending,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   sync_err,
  output logic                   cfg_err
);

  localparam frame_size_t MaxSize = '{width:  W_W'(MAX_WIDTH),
                                      height: H_W'(MAX_HEIGHT)};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  frame_size_t            act_q, act_d;
  frame_size_t            pend_q, pend_d;
  logic                   cfg_pending_q, cfg_pending_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   sync_err_q, sync_err_d;
  logic                   cfg_err_q, cfg_err_d;
  raster_state_e          state_q, state_d;

  // ---------------------------------------------------------------------------
  // Axis counters
  // ---------------------------------------------------------------------------
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           x_tc, x_wrap;
  logic           y_tc, y_wrap;
  logic           resync;
  logic           y_en;

  assign resync = en & sof_in;
  assign y_en   = en & x_wrap;

  wrap_counter #(
    .MAX_COUNT (MAX_WIDTH)
  ) u_x_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (en),
    .clr_i   (resync),
    .limit_i (act_q.width),
    .cnt_o   (x_cnt),
    .tc_o    (x_tc),
    .wrap_o  (x_wrap)
  );

  wrap_counter #(
    .MAX_COUNT (MAX_HEIGHT)
  ) u_y_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (y_en),
    .clr_i   (resync),
    .limit_i (act_q.height),
    .cnt_o   (y_cnt),
    .tc_o    (y_tc),
    .wrap_o  (y_wrap)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic at_origin;
  logic frame_done;
  logic next_origin;
  logic cfg_legal;

  always_comb begin
    at_origin   = (x_cnt == '0) && (y_cnt == '0);
    // On a resync both counters step from (0,0), so a wrap here can only be
    // a genuine frame end (or a 1x1 frame), never the aborted frame.
    frame_done  = en && x_wrap && y_wrap;
    next_origin = en ? frame_done : at_origin;
    cfg_legal   = size_in_range(32'(cfg_width), MAX_WIDTH) &&
                  size_in_range(32'(cfg_height), MAX_HEIGHT);

    sync_err_d    = resync && !at_origin;
    cfg_err_d     = cfg_load && !cfg_legal;
    frame_count_d = frame_done ? frame_count_q + FRAME_CNT_W'(1) : frame_count_q;
    state_d       = next_origin ? IDLE : ACTIVE;

    act_d         = act_q;
    pend_d        = pend_q;
    cfg_pending_d = cfg_pending_q;

    if (cfg_load && cfg_legal) begin
      pend_d.width  = cfg_width;
      pend_d.height = cfg_height;
      if (next_origin) begin
        // Boundary in this very cycle: bypass straight to the active size.
        act_d         = pend_d;
        cfg_pending_d = 1'b0;
      end else begin
        cfg_pending_d = 1'b1;
      end
    end else if (next_origin && cfg_pending_q) begin
      act_d         = pend_q;
      cfg_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q         <= MaxSize;
      pend_q        <= MaxSize;
      cfg_pending_q <= 1'b0;
      frame_count_q <= '0;
      sync_err_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      state_q       <= IDLE;
    end else begin
      act_q         <= act_d;
      pend_q        <= pend_d;
      cfg_pending_q <= cfg_pending_d;
      frame_count_q <= frame_count_d;
      sync_err_q    <= sync_err_d;
      cfg_err_q     <= cfg_err_d;
      state_q       <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign x           = x_cnt;
  assign y           = y_cnt;
  assign sol         = (x_cnt == '0);
  assign eol         = x_tc;
  assign sof         = at_origin;
  assign eof         = x_tc && y_tc;
  // IDLE is entered exactly when the next position is (0,0).
  assign in_frame    = (state_q == ACTIVE);
  assign cfg_pending = cfg_pending_q;
  assign frame_count = frame_count_q;
  assign sync_err    = sync_err_q;
  assign cfg_err     = cfg_err_q;

endmodule
